// File: rtl/retry_pkg.sv
// ---------------------------------------------------------------------------
// retry_pkg
// Shared types and constants for the retry pipeline stages.
//   RETRY_FB_T(IDW) : packed {valid, id} feedback record. It is a macro
//                     because a package cannot take parameters, and each
//                     stage needs the record at its own IDSize.
//   retry_fb_t      : the feedback record at the default 4-bit ID width.
//   RetryDefaultMaxRetries : default retry budget per item.
// ---------------------------------------------------------------------------
`ifndef RETRY_PKG_SV
`define RETRY_PKG_SV

`define RETRY_FB_T(IDW) struct packed { logic valid; logic [(IDW)-1:0] id; }

package retry_pkg;

   localparam int RetryDefaultMaxRetries = 3;

   typedef `RETRY_FB_T(4) retry_fb_t;

endpackage

`endif

// File: rtl/retry_replay_buffer.sv
// ---------------------------------------------------------------------------
// retry_replay_buffer
// Circular replay store for the retry source stage: payload slots, per-slot
// retry counters and the head/issue/tail pointers. Pointers are one bit wider
// than the slot index so that full and empty can be told apart.
//
// Ports
//   clk, rst_n  : clock; reset is asynchronous and active-high (the
//                 codebase's historical rst_n naming is kept)
//   wr_en       : write wr_data at tail, clear that slot's counter, tail++
//   wr_data     : payload to store
//   issue_adv   : downstream handshake, issue++
//   pop         : retire the head slot, clear its counter, head++
//   cnt_inc     : increment the head slot's retry counter
//   rewind      : issue := head (highest priority on issue)
//   skip        : issue := head + 1 (used when the head item is dropped)
//   head, issue, tail : current pointers
//   rd_data     : payload at issue
//   head_cnt    : retry counter of the head slot
// ---------------------------------------------------------------------------
module retry_replay_buffer #(
   parameter int DataWidth = 8,
   parameter int IDSize    = 4,
   parameter int CntWidth  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 issue_adv,
   input  logic                 pop,
   input  logic                 cnt_inc,
   input  logic                 rewind,
   input  logic                 skip,
   output logic [IDSize:0]      head,
   output logic [IDSize:0]      issue,
   output logic [IDSize:0]      tail,
   output logic [DataWidth-1:0] rd_data,
   output logic [CntWidth-1:0]  head_cnt
);

   localparam int Depth = 2**IDSize;

   logic [DataWidth-1:0] mem [Depth];
   logic [CntWidth-1:0]  cnt [Depth];

   logic [IDSize-1:0] head_idx;
   logic [IDSize-1:0] issue_idx;
   logic [IDSize-1:0] tail_idx;

   assign head_idx  = head[IDSize-1:0];
   assign issue_idx = issue[IDSize-1:0];
   assign tail_idx  = tail[IDSize-1:0];

   assign rd_data  = mem[issue_idx];
   assign head_cnt = cnt[head_idx];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         head  <= '0;
         issue <= '0;
         tail  <= '0;
      end else begin
         if (wr_en) tail <= tail + 1'b1;
         if (pop)   head <= head + 1'b1;
         // A rewind or a drop moves issue relative to the old head, so it
         // wins over a handshake made in the same cycle.
         if (rewind)         issue <= head;
         else if (skip)      issue <= head + 1'b1;
         else if (issue_adv) issue <= issue + 1'b1;
      end
   end

   // NOTE: the payload array is reset as well, so data_o reads 0 out of
   // reset instead of X; it is small enough that this costs little.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         // A write never targets the head slot while it is being popped or
         // counted: that would need the buffer to be full, and then wr_en
         // is held low.
         if (wr_en) begin
            mem[tail_idx] <= wr_data;
            cnt[tail_idx] <= '0;
         end
         if (pop)          cnt[head_idx] <= '0;
         else if (cnt_inc) cnt[head_idx] <= cnt[head_idx] + 1'b1;
      end
   end

endmodule

// File: rtl/retry_replay_start.sv
// ---------------------------------------------------------------------------
// retry_replay_start
// Retry source stage. Tags upstream items with an ID, keeps a copy in a
// replay buffer, issues items in order, and retires or replays them
// (go-back-N from the oldest outstanding item) on feedback from the retry end
// stage. An item that fails more than MaxRetries times is dropped, and an
// exhausted pulse is raised.
//
// Ports
//   clk, rst_n        : clock; reset is asynchronous and active-high
//   data_i/valid_i/ready_o   : upstream payload handshake
//   data_o/id_o/valid_o/ready_i : downstream payload handshake
//   done_valid_i/done_id_i   : end stage reports an item complete
//   retry_valid_i/retry_id_i : end stage requests a replay
//   exhausted_o/exhausted_id_o : one-cycle pulse, item dropped after MaxRetries
//   protocol_err_o    : one-cycle pulse, illegal done/retry was ignored
//   occupancy_o       : entries held between head and tail
// ---------------------------------------------------------------------------
module retry_replay_start
   import retry_pkg::*;
#(
   parameter int DataWidth  = 8,
   parameter int IDSize     = 4,
   parameter int MaxRetries = RetryDefaultMaxRetries,
   parameter int CntWidth   = $clog2(MaxRetries + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic [IDSize-1:0]    id_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   input  logic                 done_valid_i,
   input  logic [IDSize-1:0]    done_id_i,
   input  logic                 retry_valid_i,
   input  logic [IDSize-1:0]    retry_id_i,
   output logic                 exhausted_o,
   output logic [IDSize-1:0]    exhausted_id_o,
   output logic                 protocol_err_o,
   output logic [IDSize:0]      occupancy_o
);

   typedef `RETRY_FB_T(IDSize) fb_t;

   localparam logic [IDSize:0] DepthCount = {1'b1, {IDSize{1'b0}}};

   fb_t done_fb;
   fb_t retry_fb;

   logic [IDSize:0]       head;
   logic [IDSize:0]       issue;
   logic [IDSize:0]       tail;
   logic [CntWidth-1:0]   head_cnt;
   logic [IDSize-1:0]     head_id;

   logic outstanding;
   logic done_ok;
   logic retry_ok;
   logic at_limit;
   logic rewind;
   logic exhaust;
   logic proto_err;
   logic wr_en;
   logic issue_hs;

   assign done_fb  = '{valid: done_valid_i,  id: done_id_i};
   assign retry_fb = '{valid: retry_valid_i, id: retry_id_i};

   // Upstream and downstream flow control come from registered pointers only.
   assign occupancy_o = tail - head;
   assign ready_o     = (occupancy_o != DepthCount);
   assign valid_o     = (issue != tail);
   assign id_o        = issue[IDSize-1:0];
   assign wr_en       = valid_i & ready_o;
   assign issue_hs    = valid_o & ready_i;

   // NOTE: every signal written below gets a value on every path, so the
   // block stays purely combinational.
   always_comb begin
      head_id     = head[IDSize-1:0];
      outstanding = (head != issue);
      done_ok     = done_fb.valid && outstanding && (done_fb.id == head_id);
      // A done in the same cycle takes precedence; the retry is rejected.
      retry_ok    = retry_fb.valid && !done_fb.valid && outstanding &&
                    (retry_fb.id == head_id);
      at_limit    = (head_cnt == CntWidth'(MaxRetries));
      rewind      = retry_ok && !at_limit;
      exhaust     = retry_ok && at_limit;
      proto_err   = (done_fb.valid && !done_ok) || (retry_fb.valid && !retry_ok);
   end

   retry_replay_buffer #(
      .DataWidth (DataWidth),
      .IDSize    (IDSize),
      .CntWidth  (CntWidth)
   ) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (data_i),
      .issue_adv (issue_hs),
      .pop       (done_ok | exhaust),
      .cnt_inc   (rewind),
      .rewind    (rewind),
      .skip      (exhaust),
      .head      (head),
      .issue     (issue),
      .tail      (tail),
      .rd_data   (data_o),
      .head_cnt  (head_cnt)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         exhausted_o    <= 1'b0;
         exhausted_id_o <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         exhausted_o    <= exhaust;
         protocol_err_o <= proto_err;
         if (exhaust) exhausted_id_o <= head_id;
      end
   end

endmodule

// File: tb/tb_retry_replay_start.sv
// ---------------------------------------------------------------------------
// tb_retry_replay_start
// Self-checking bench. The reference model keeps the live items as a queue
// (oldest first) plus the count of items already sent downstream; every
// cycle the DUT outputs are compared with what that queue implies.
// ---------------------------------------------------------------------------
module tb_retry_replay_start;

   localparam int DataWidth  = 8;
   localparam int IDSize     = 4;
   localparam int MaxRetries = 3;
   localparam int Depth      = 16;

   logic                 clk;
   logic                 rst_n;
   logic [DataWidth-1:0] data_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [DataWidth-1:0] data_o;
   logic [IDSize-1:0]    id_o;
   logic                 valid_o;
   logic                 ready_i;
   logic                 done_valid_i;
   logic [IDSize-1:0]    done_id_i;
   logic                 retry_valid_i;
   logic [IDSize-1:0]    retry_id_i;
   logic                 exhausted_o;
   logic [IDSize-1:0]    exhausted_id_o;
   logic                 protocol_err_o;
   logic [IDSize:0]      occupancy_o;

   retry_replay_start #(
      .DataWidth  (DataWidth),
      .IDSize     (IDSize),
      .MaxRetries (MaxRetries)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_i         (data_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .data_o         (data_o),
      .id_o           (id_o),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .done_valid_i   (done_valid_i),
      .done_id_i      (done_id_i),
      .retry_valid_i  (retry_valid_i),
      .retry_id_i     (retry_id_i),
      .exhausted_o    (exhausted_o),
      .exhausted_id_o (exhausted_id_o),
      .protocol_err_o (protocol_err_o),
      .occupancy_o    (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] data;
      logic [3:0] id;
      int         retries;
   } item_t;

   item_t      q[$];
   int         issued;
   int         next_id;
   bit         exp_exh;
   logic [3:0] exp_exh_id;
   bit         exp_err;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] head_id();
      if (q.size() > 0) return q[0].id;
      return 4'h0;
   endfunction

   task automatic model_reset();
      q.delete();
      issued     = 0;
      next_id    = 0;
      exp_exh    = 0;
      exp_exh_id = '0;
      exp_err    = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ":ready"}, 32'(ready_o), 32'(q.size() < Depth));
      check({tag, ":valid"}, 32'(valid_o), 32'(issued < q.size()));
      check({tag, ":occ"}, 32'(occupancy_o), 32'(q.size()));
      if (issued < q.size()) begin
         check({tag, ":data"}, 32'(data_o), 32'(q[issued].data));
         check({tag, ":id"}, 32'(id_o), 32'(q[issued].id));
      end
      check({tag, ":exh"}, 32'(exhausted_o), 32'(exp_exh));
      if (exp_exh) check({tag, ":exh_id"}, 32'(exhausted_id_o), 32'(exp_exh_id));
      check({tag, ":perr"}, 32'(protocol_err_o), 32'(exp_err));
   endtask

   // Drive one cycle of inputs, advance the model by the same rules, then
   // sample the DUT 1 time unit after the clock edge.
   task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                        input logic rdy, input logic dv, input logic [3:0] did,
                        input logic rv, input logic [3:0] rid);
      int    sz;
      bit    vo;
      bit    has_issued;
      bit    done_ok;
      bit    retry_hit;
      item_t it;
      valid_i       = v;
      data_i        = d;
      ready_i       = rdy;
      done_valid_i  = dv;
      done_id_i     = did;
      retry_valid_i = rv;
      retry_id_i    = rid;

      sz         = q.size();
      vo         = issued < sz;
      has_issued = issued > 0;
      done_ok    = dv && has_issued && (did == head_id());
      retry_hit  = rv && has_issued && (rid == head_id());
      exp_exh    = 0;
      exp_err    = (dv && !done_ok) || (rv && (dv || !retry_hit));

      if (rv && !dv && retry_hit) begin
         if (q[0].retries < MaxRetries) begin
            it = q[0];
            it.retries = it.retries + 1;
            q[0] = it;
         end else begin
            exp_exh    = 1;
            exp_exh_id = q[0].id;
            void'(q.pop_front());
         end
         issued = 0;
      end else begin
         if (done_ok) begin
            void'(q.pop_front());
            issued--;
         end
         if (vo && rdy) issued++;
      end

      if (v && sz < Depth) begin
         it.data    = d;
         it.id      = next_id[3:0];
         it.retries = 0;
         q.push_back(it);
         next_id++;
      end

      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      cycle(tag, 1'b0, 8'h00, rdy, 1'b0, 4'h0, 1'b0, 4'h0);
   endtask

   // Issue and complete everything still held, bounded by a cycle budget.
   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         cycle(tag, 1'b0, 8'h00, 1'b1, issued > 0, head_id(), 1'b0, 4'h0);
         guard++;
      end
      check({tag, ":drained_occ"}, 32'(occupancy_o), 32'd0);
      check({tag, ":drained_ready"}, 32'(ready_o), 32'd1);
   endtask

   logic [3:0] saved_id;
   int         pushed;

   initial begin
      rst_n         = 1'b1;
      data_i        = '0;
      valid_i       = 1'b0;
      ready_i       = 1'b0;
      done_valid_i  = 1'b0;
      done_id_i     = '0;
      retry_valid_i = 1'b0;
      retry_id_i    = '0;
      model_reset();

      // Reset state
      #12;
      check("rst:ready", 32'(ready_o), 32'd1);
      check("rst:valid", 32'(valid_o), 32'd0);
      check("rst:occ", 32'(occupancy_o), 32'd0);
      check("rst:exh", 32'(exhausted_o), 32'd0);
      check("rst:perr", 32'(protocol_err_o), 32'd0);
      check("rst:data", 32'(data_o), 32'd0);
      check("rst:id", 32'(id_o), 32'd0);
      check("rst:exh_id", 32'(exhausted_id_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;

      // Flow without feedback: one-cycle latency, in-order IDs
      cycle("flow", 1'b1, 8'h11, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
      check("flow:first_id", 32'(id_o), 32'd0);
      check("flow:first_data", 32'(data_o), 32'h11);
      cycle("flow", 1'b1, 8'h22, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
      cycle("flow", 1'b1, 8'h33, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
      check("flow:occ3", 32'(occupancy_o), 32'd3);
      idle("flow", 1'b1);
      drain("flow");

      // Fill to full with downstream stalled
      for (int i = 0; i < Depth; i++)
         cycle("fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      check("fill:ready_low", 32'(ready_o), 32'd0);
      cycle("fill_over", 1'b1, 8'hEE, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      drain("fill");

      // Rewind: four items sent, retry the oldest
      cycle("rew", 1'b1, 8'h11, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      cycle("rew", 1'b1, 8'h22, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      cycle("rew", 1'b1, 8'h33, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      cycle("rew", 1'b1, 8'h44, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) idle("rew_issue", 1'b1);
      cycle("rew_retry", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, head_id());
      check("rew:replay_data", 32'(data_o), 32'h11);
      for (int i = 0; i < 4; i++) idle("rew_reissue", 1'b1);

      // Exhaustion: three more retries of the same head item
      for (int k = 0; k < 3; k++) begin
         idle("exh_issue", 1'b1);
         saved_id = head_id();
         cycle("exh_retry", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, head_id());
      end
      check("exh:pulse", 32'(exhausted_o), 32'd1);
      check("exh:id", 32'(exhausted_id_o), 32'(saved_id));
      check("exh:next_id", 32'(id_o), 32'(saved_id + 4'd1));
      check("exh:next_data", 32'(data_o), 32'h22);
      idle("exh_after", 1'b0);

      // Illegal feedback
      idle("ill_issue", 1'b1);
      cycle("ill_done", 1'b0, 8'h00, 1'b0, 1'b1, head_id() + 4'd2, 1'b0, 4'h0);
      check("ill:perr_wrong_id", 32'(protocol_err_o), 32'd1);
      cycle("ill_both", 1'b0, 8'h00, 1'b0, 1'b1, head_id(), 1'b1, head_id());
      check("ill:perr_both", 32'(protocol_err_o), 32'd1);
      cycle("ill_retry_unissued", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1, head_id());
      drain("ill");

      // Random traffic with wrap-around
      pushed = 0;
      for (int c = 0; c < 3000 && (pushed < 40 || q.size() > 0); c++) begin
         logic       v;
         logic       rdy;
         logic       dv;
         logic       rv;
         logic [3:0] h;
         v   = (pushed < 40) && ($urandom_range(0, 1) == 1);
         if (v && q.size() < Depth) pushed++;
         rdy = ($urandom_range(0, 3) != 0);
         h   = head_id();
         dv  = 1'b0;
         rv  = 1'b0;
         if (issued > 0 && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 14) == 0) rv = 1'b1;
            else                            dv = 1'b1;
         end
         cycle("rand", v, 8'($urandom), rdy, dv, h, rv, h);
      end
      check("rand:all_pushed", 32'(pushed), 32'd40);
      check("rand:drained", 32'(occupancy_o), 32'd0);

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 5; i++)
         cycle("mid", 1'b1, 8'($urandom), 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      idle("mid", 1'b1);
      #2;
      rst_n = 1'b1;
      #1;
      model_reset();
      check("arst:occ", 32'(occupancy_o), 32'd0);
      check("arst:valid", 32'(valid_o), 32'd0);
      check("arst:ready", 32'(ready_o), 32'd1);
      check("arst:exh", 32'(exhausted_o), 32'd0);
      check("arst:perr", 32'(protocol_err_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      cycle("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
      check("post_rst:id", 32'(id_o), 32'd0);
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
